// File: rtl/hamming_weight_enumerator_if.sv
// Stream and control bundle for hamming_weight_enumerator.
// The enumerator takes the master modport; the consumer/controller takes slave.
interface hamming_weight_enumerator_if #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
);
    // Handshake: a word moves on a rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_value/out_last stay stable,
    // and out_ready may be asserted before out_valid rises.
    logic             start;
    logic [KW-1:0]    weight;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_value;
    logic             out_last;
    logic [WIDTH-1:0] emitted;
    logic             busy;
    logic             done;
    logic             error;
    logic             state_dbg;

    modport master (
        input  start, weight, abort, out_ready,
        output out_valid, out_value, out_last, emitted, busy, done, error, state_dbg
    );

    modport slave (
        output start, weight, abort, out_ready,
        input  out_valid, out_value, out_last, emitted, busy, done, error, state_dbg
    );
endinterface

// File: rtl/hamming_weight_enumerator.sv
// Streams every WIDTH-bit word with popcount k in ascending order, one word
// per cycle when the consumer is ready, stepping with Gosper's hack.
module hamming_weight_enumerator #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input logic                       clk,
    input logic                       rst_n,
    hamming_weight_enumerator_if.master bus
);
    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH:0]   ONE_W    = (WIDTH + 1)'(1);

    state_t           state, state_n;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] value_q;
    logic             valid_q;
    logic             last_q;
    logic [WIDTH-1:0] emitted_q;
    logic             done_q;
    logic             error_q;

    logic load, advance, finish, kill, err_go;

    // Gosper's step, one bit wider than the word so the carry out of r survives.
    logic [WIDTH:0]   xw, c, r;
    logic [KW-1:0]    ctz;
    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] final_word;
    logic [WIDTH-1:0] emitted_inc;

    always_comb begin
        xw  = {1'b0, value_q};
        c   = xw & (~xw + ONE_W);
        r   = xw + c;
        ctz = '0;
        for (int i = WIDTH; i >= 0; i--) begin
            if (c[i]) ctz = KW'(i);
        end
        x_next = WIDTH'(r | (((r ^ xw) >> 2) >> ctz));
    end

    // Lowest and highest words of weight k; shifts past WIDTH give 0/all-ones.
    always_comb begin
        first_word  = ~(ALL_ONES << bus.weight);
        final_word  = ~(ALL_ONES >> k_q);
        emitted_inc = (emitted_q == ALL_ONES) ? emitted_q : emitted_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        kill    = 1'b0;
        err_go  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.weight > KW'(WIDTH)) begin
                        err_go = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_n = EMIT;
                    end
                end
            end
            EMIT: begin
                // abort wins over a handshake in the same cycle
                if (bus.abort) begin
                    kill    = 1'b1;
                    state_n = IDLE;
                end else if (valid_q && bus.out_ready) begin
                    if (last_q) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            emitted_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= finish;
            error_q <= err_go;
            if (load) begin
                k_q       <= bus.weight;
                value_q   <= first_word;
                valid_q   <= 1'b1;
                last_q    <= (first_word == ~(ALL_ONES >> bus.weight));
                emitted_q <= '0;
            end else if (kill) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (finish) begin
                valid_q   <= 1'b0;
                last_q    <= 1'b0;
                emitted_q <= emitted_inc;
            end else if (advance) begin
                value_q   <= x_next;
                last_q    <= (x_next == final_word);
                emitted_q <= emitted_inc;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_value = value_q;
    assign bus.out_last  = last_q;
    assign bus.emitted   = emitted_q;
    assign bus.busy      = (state == EMIT);
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_hamming_weight_enumerator.sv
// Bench for hamming_weight_enumerator: random ready/start noise against a
// model that lists all weight-k words by brute-force popcount.
module tb_hamming_weight_enumerator;
    localparam int W  = 8;
    localparam int KW = $clog2(W + 1);

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [W-1:0] exp_q[$];

    hamming_weight_enumerator_if #(.WIDTH(W), .KW(KW)) bus ();

    hamming_weight_enumerator #(.WIDTH(W), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference: every word with popcount k, in ascending numeric order
    task automatic build_model(input int k);
        exp_q.delete();
        for (int v = 0; v < (1 << W); v++) begin
            if ($countones(v[W-1:0]) == k) exp_q.push_back(v[W-1:0]);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"},   32'(bus.out_valid), 0);
        check({tag, "_value"},   32'(bus.out_value), 0);
        check({tag, "_last"},    32'(bus.out_last),  0);
        check({tag, "_emitted"}, 32'(bus.emitted),   0);
        check({tag, "_busy"},    32'(bus.busy),      0);
        check({tag, "_done"},    32'(bus.done),      0);
        check({tag, "_error"},   32'(bus.error),     0);
    endtask

    // driver: called at a negedge, returns at a negedge.
    // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on 0x0B.
    task automatic run_stream(input int k, input int mode, input int abort_at);
        int  hs;
        int  total;
        int  hold;
        int  budget;
        bit  fin;
        bit  rdy;
        build_model(k);
        total = exp_q.size();
        bus.start  = 1'b1;
        bus.weight = KW'(k);
        @(negedge clk);
        hs = 0; hold = 0; budget = 0; fin = 1'b0;
        while (!fin && budget < 2000) begin
            check("stream_valid",   32'(bus.out_valid), 1);
            check("stream_value",   32'(bus.out_value), 32'(exp_q[0]));
            check("stream_last",    32'(bus.out_last),  32'(exp_q.size() == 1));
            check("stream_emitted", 32'(bus.emitted),   32'(hs));
            check("stream_busy",    32'(bus.busy),      1);
            check("stream_done",    32'(bus.done),      0);
            // start noise while busy must be ignored
            bus.start  = 1'($urandom_range(0, 1));
            bus.weight = KW'($urandom_range(0, W));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (exp_q[0] == 8'h0B && hold < 3) begin
                        rdy = 1'b0;
                        hold++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            if (hs == abort_at) begin
                bus.abort     = 1'b1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                bus.start = 1'b0;
                check("abort_valid",   32'(bus.out_valid), 0);
                check("abort_busy",    32'(bus.busy),      0);
                check("abort_emitted", 32'(bus.emitted),   32'(abort_at));
                check("abort_done",    32'(bus.done),      0);
                @(negedge clk);
                check("abort_done2",   32'(bus.done),      0);
                check("abort_state",   32'(bus.state_dbg), 0);
                fin = 1'b1;
            end else begin
                bus.out_ready = rdy;
                if (rdy) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
                @(negedge clk);
                budget++;
                bus.start = 1'b0;
                if (rdy && exp_q.size() == 0) begin
                    check("done_pulse",   32'(bus.done),      1);
                    check("done_valid",   32'(bus.out_valid), 0);
                    check("done_last",    32'(bus.out_last),  0);
                    check("done_busy",    32'(bus.busy),      0);
                    check("done_emitted", 32'(bus.emitted),   32'(total));
                    fin = 1'b1;
                end
            end
        end
        if (!fin) check("stream_timeout", 0, 1);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
    endtask

    initial begin
        int kbad;
        errors = 0;
        checks = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.weight    = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // abort in IDLE is ignored
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 0);

        run_stream(2, 0, -1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 0);
        run_stream(4, 1, -1);
        run_stream(0, 0, -1);
        // back-to-back start in the done cycle
        run_stream(7, 1, -1);
        run_stream(8, 1, -1);

        kbad = $urandom_range(W + 1, (1 << KW) - 1);
        bus.start  = 1'b1;
        bus.weight = KW'(kbad);
        @(negedge clk);
        bus.start = 1'b0;
        check("err_pulse", 32'(bus.error),     1);
        check("err_valid", 32'(bus.out_valid), 0);
        check("err_busy",  32'(bus.busy),      0);
        @(negedge clk);
        check("err_pulse_end", 32'(bus.error),     0);
        check("err_valid2",    32'(bus.out_valid), 0);

        run_stream(3, 2, -1);
        run_stream(5, 1, 10);
        run_stream(1, 0, -1);
        for (int n = 0; n < 4; n++) begin
            run_stream($urandom_range(0, W), 1, -1);
        end

        // asynchronous reset mid-run
        bus.start     = 1'b1;
        bus.weight    = KW'(6);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("async_rst");
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 0);
        run_stream(8, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
